register_bank: RTL and testbench

- Parametrised successor to the single 16-bit LOAD/INC register.
- Holds NREGS registers of WIDTH bits, each with its own carry flag.
- Each cycle, one opcode is applied to every register whose write-select bit is set.
- Two independent combinational read ports feed the datapath (ALU operands, PC/AR/IR style registers) of the Spartan-6 CPU.

---
 rtl/register_bank_pkg.sv | 16 +
 rtl/register_cell.sv | 67 ++++++
 rtl/register_bank.sv | 47 ++++
 tb/tb_register_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Opcode encoding shared by the register bank and the CPU control state machine.
// The low two bits match the original LOAD/DEC/INC register encoding.
package register_bank_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_IDLE = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b010;
  localparam logic [OP_W-1:0] OP_INC  = 3'b011;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b100;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b111;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register with its own carry flag.
// When enabled, it applies the shared opcode to its own old value.
module register_cell
  import register_bank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] value,
  output logic             carry_flag
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] value_next;
  logic             carry_next;

  always_comb begin
    value_next = value;
    carry_next = carry_flag;
    case (op)
      OP_LOAD: begin
        value_next = data_in;
        carry_next = 1'b0;
      end
      OP_DEC: begin
        value_next = value - ONE;
        carry_next = (value == '0);
      end
      OP_INC: begin
        value_next = value + ONE;
        carry_next = &value;
      end
      OP_CLR: begin
        value_next = '0;
        carry_next = 1'b0;
      end
      OP_ADD: {carry_next, value_next} = {1'b0, value} + {1'b0, data_in};
      OP_SHL: begin
        value_next = {value[WIDTH-2:0], 1'b0};
        carry_next = value[WIDTH-1];
      end
      OP_SHR: begin
        value_next = {1'b0, value[WIDTH-1:1]};
        carry_next = value[0];
      end
      default: ;
    endcase
  end

  // Reset wins over any op in flight; an asserted reset discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= RESET_VAL;
      carry_flag <= 1'b0;
    end else if (en) begin
      value      <= value_next;
      carry_flag <= carry_next;
    end
  end

endmodule

// File: rtl/register_bank.sv
// NREGS x WIDTH register bank with per-register carry, multi-select writes
// and two combinational read ports (no read-during-write bypass).
module register_bank
  import register_bank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              NREGS     = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   sm_op,
  input  logic [NREGS-1:0]  selection,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              carry_a,
  output logic              zero_a,
  output logic [NREGS-1:0]  carry
);

  logic [WIDTH-1:0] reg_value [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cell
    register_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (selection[gi]),
      .op         (sm_op),
      .data_in    (data_in),
      .value      (reg_value[gi]),
      .carry_flag (carry[gi])
    );
  end

  assign data_out_a = reg_value[rd_addr_a];
  assign data_out_b = reg_value[rd_addr_b];
  assign carry_a    = carry[rd_addr_a];
  assign zero_a     = (data_out_a == '0);

endmodule

// File: tb/tb_register_bank.sv
// Directed scoreboard bench for register_bank: stimulus queues expected read-port
// state, a negedge monitor pops and compares it against the DUT.
module tb_register_bank;
  import register_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sm_op;
  logic [7:0]  selection;
  logic [15:0] data_in;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] data_out_a;
  logic [15:0] data_out_b;
  logic        carry_a;
  logic        zero_a;
  logic [7:0]  carry;

  typedef struct {
    string       name;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [7:0]  ec;
    logic        ez;
    logic        eca;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  register_bank #(
    .WIDTH     (16),
    .ADDR_W    (3),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sm_op      (sm_op),
    .selection  (selection),
    .data_in    (data_in),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .carry_a    (carry_a),
    .zero_a     (zero_a),
    .carry      (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, expv);
    end
  endtask

  // Monitor: compares every queued expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t it;
        it = exp_q.pop_front();
        chk(it.name, "data_out_a", data_out_a, it.ea);
        chk(it.name, "data_out_b", data_out_b, it.eb);
        chk(it.name, "carry", {8'h00, carry}, {8'h00, it.ec});
        chk(it.name, "zero_a", {15'h0, zero_a}, {15'h0, it.ez});
        chk(it.name, "carry_a", {15'h0, carry_a}, {15'h0, it.eca});
        $display("check %s: a=%h b=%h carry=%h zero_a=%b carry_a=%b", it.name,
                 data_out_a, data_out_b, carry, zero_a, carry_a);
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [7:0] s, input logic [15:0] d);
    sm_op     = o;
    selection = s;
    data_in   = d;
    @(posedge clk);
    #1;
    sm_op     = OP_IDLE;
    selection = 8'h00;
    data_in   = 16'h0000;
  endtask

  task automatic expect_state(input string name, input logic [2:0] aa, input logic [2:0] ab,
                              input logic [15:0] ea, input logic [15:0] eb, input logic [7:0] ec,
                              input logic ez, input logic eca);
    exp_t it;
    rd_addr_a = aa;
    rd_addr_b = ab;
    it.name = name; it.ea = ea; it.eb = eb; it.ec = ec; it.ez = ez; it.eca = eca;
    exp_q.push_back(it);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sm_op = OP_IDLE; selection = 8'h00; data_in = 16'h0000;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_state("reset_state", 0, 1, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);

    // Async reset mid-operation: everything clears before any edge, op is discarded.
    do_op(OP_LOAD, 8'hFF, 16'h7777);
    do_op(OP_SHR, 8'hFF, 16'h0000);
    expect_state("shr_all", 0, 7, 16'h3BBB, 16'h3BBB, 8'hFF, 1'b0, 1'b1);
    sm_op = OP_LOAD; selection = 8'hFF; data_in = 16'hAAAA;
    #1 rst_n = 1'b0;
    expect_state("async_reset", 0, 7, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    sm_op = OP_IDLE; selection = 8'h00; rst_n = 1'b1;
    expect_state("reset_discard", 3, 7, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);
    do_op(OP_LOAD, 8'h04, 16'h1234);
    expect_state("load_r2", 2, 0, 16'h1234, 16'h0000, 8'h00, 1'b0, 1'b0);

    // Wrap and borrow on r5.
    do_op(OP_LOAD, 8'h20, 16'hFFFF);
    do_op(OP_INC, 8'h20, 16'h0000);
    expect_state("inc_wrap", 5, 2, 16'h0000, 16'h1234, 8'h20, 1'b1, 1'b1);
    do_op(OP_DEC, 8'h20, 16'h0000);
    expect_state("dec_borrow", 5, 2, 16'hFFFF, 16'h1234, 8'h20, 1'b0, 1'b1);

    // ADD carry out and carry clear on r1.
    do_op(OP_LOAD, 8'h02, 16'h8001);
    do_op(OP_ADD, 8'h02, 16'h8000);
    expect_state("add_carry", 1, 5, 16'h0001, 16'hFFFF, 8'h22, 1'b0, 1'b1);
    do_op(OP_ADD, 8'h02, 16'h0002);
    expect_state("add_nocarry", 1, 5, 16'h0003, 16'hFFFF, 8'h20, 1'b0, 1'b0);

    // Shifts on r3.
    do_op(OP_LOAD, 8'h08, 16'h8001);
    do_op(OP_SHL, 8'h08, 16'h0000);
    expect_state("shl", 3, 1, 16'h0002, 16'h0003, 8'h28, 1'b0, 1'b1);
    do_op(OP_SHR, 8'h08, 16'h0000);
    expect_state("shr1", 3, 1, 16'h0001, 16'h0003, 8'h20, 1'b0, 1'b0);
    do_op(OP_SHR, 8'h08, 16'h0000);
    expect_state("shr2", 3, 1, 16'h0000, 16'h0003, 8'h28, 1'b1, 1'b1);

    // Multi-select INC on r0 and r7; others untouched.
    do_op(OP_LOAD, 8'h01, 16'h0010);
    do_op(OP_LOAD, 8'h80, 16'h00FF);
    do_op(OP_INC, 8'h81, 16'h0000);
    expect_state("multi_inc", 0, 7, 16'h0011, 16'h0100, 8'h28, 1'b0, 1'b0);
    expect_state("multi_other", 2, 5, 16'h1234, 16'hFFFF, 8'h28, 1'b0, 1'b0);

    // Read during write on r4: old value before the edge, new value after.
    do_op(OP_LOAD, 8'h10, 16'h00AA);
    sm_op = OP_LOAD; selection = 8'h10; data_in = 16'h5555;
    expect_state("rdw_before", 4, 4, 16'h00AA, 16'h00AA, 8'h28, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sm_op = OP_IDLE; selection = 8'h00; data_in = 16'h0000;
    expect_state("rdw_after", 4, 4, 16'h5555, 16'h5555, 8'h28, 1'b0, 1'b0);

    do_op(OP_IDLE, 8'hFF, 16'hFFFF);
    expect_state("idle_hold", 4, 1, 16'h5555, 16'h0003, 8'h28, 1'b0, 1'b0);
    do_op(OP_CLR, 8'h20, 16'h0000);
    expect_state("clr_r5", 5, 7, 16'h0000, 16'h0100, 8'h08, 1'b1, 1'b0);

    stim_done = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    while (!stim_done && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: stim_done=%0d pending=%0d required done with 0 pending",
               stim_done, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
